// File: rtl/pmc_pkg.sv
// Shared constants for the performance monitoring counter block.
// Latency: n/a (constants and a pure classification function).
// Backpressure: n/a.
//
// Contents: opcode and branch encodings, the Q7.8 value of 1.0, and the
// arithmetic-opcode classifier used by pmc_unit.
package pmc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b010000;
   localparam logic [5:0] OP_FP    = 6'b000100;
   localparam logic [5:0] OP_VFP   = 6'b001100;
   localparam logic [5:0] OP_VSET  = 6'b111111;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_LT   = 2'b10;

   localparam logic [15:0] Q78_ONE = 16'h0100;

   // True only for the opcodes that count as arithmetic work. VSET, 000011
   // and all branch/jump opcodes fall through to 0.
   function automatic logic is_arith_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDI) ||
             (op == OP_FP)    || (op == OP_VFP);
   endfunction

endpackage

// File: rtl/pmc_q78_div.sv
// Unsigned Q7.8 ratio num/den: floor(num * 256 / den), saturated to 16 bits.
// Latency: combinational (0 cycles).
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports: num (CNT_W) dividend before scaling, den (CNT_W) divisor,
//        q (16) Q7.8 quotient; den == 0 yields 0.
module pmc_q78_div
   import pmc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic [CNT_W-1:0] num,
   input  logic [CNT_W-1:0] den,
   output logic [15:0]      q
);

   localparam int DW = CNT_W + 8;

   logic [DW-1:0] dividend;
   logic [DW-1:0] divisor;
   logic [DW-1:0] quot;

   // Scaling by Q78_ONE (256) widens the dividend by exactly 8 bits.
   assign dividend = DW'(num) * DW'(Q78_ONE);
   assign divisor  = DW'(den);

   always_comb begin
      quot = '0;
      q    = '0;
      if (den != '0) begin
         quot = dividend / divisor;
         if (|quot[DW-1:16]) begin
            q = 16'hFFFF;
         end else begin
            q = quot[15:0];
         end
      end
   end

endmodule

// File: rtl/pmc_unit.sv
// Execute-stage performance counters: stalls, arithmetic and memory-access
// instructions, plus average CPI in unsigned Q7.8.
// Latency: counters reflect an event 1 cycle later; CPI lags its counters by 1 cycle.
// Backpressure: none; samples the execute stage every clock unconditionally.
//
// Ports: clk, reset (async, active-low), execute-stage controls
//        (memWrite_in, memToReg_in, aluControl_in, stall_enable, opcode_in,
//        funct_in, jmp_in, branch_in); outputs stall_count, arith_count,
//        mem_access_count, cycles_per_instruction_q78 (all OUT_W wide).
// Build option: define PMC_CPI_EN to build the cycle/instruction counters and
// the CPI divider; otherwise cycles_per_instruction_q78 is tied to 0.
module pmc_unit
   import pmc_pkg::*;
#(
   parameter int OUT_W = 256,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memWrite_in,
   input  logic             memToReg_in,
   input  logic [2:0]       aluControl_in,
   input  logic [1:0]       stall_enable,
   input  logic [5:0]       opcode_in,
   input  logic [5:0]       funct_in,
   input  logic             jmp_in,
   input  logic [1:0]       branch_in,
   output logic [OUT_W-1:0] stall_count,
   output logic [OUT_W-1:0] cycles_per_instruction_q78,
   output logic [OUT_W-1:0] arith_count,
   output logic [OUT_W-1:0] mem_access_count
);

   logic stall;
   logic arith_hit;
   logic mem_hit;

   // Either hazard bit stalls the stage; both together are still one stall cycle.
   assign stall = |stall_enable;

   // Any memory, jump or branch flag disqualifies the instruction even if the
   // opcode itself is an arithmetic one.
   assign arith_hit = !stall && !memWrite_in && !memToReg_in && !jmp_in &&
                      (branch_in == BR_NONE) && is_arith_op(opcode_in);

   assign mem_hit = !stall && (memWrite_in || memToReg_in);

   // ALU op and funct are carried for observability only.
   logic unused_inputs;
   assign unused_inputs = ^{aluControl_in, funct_in};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count      <= '0;
         arith_count      <= '0;
         mem_access_count <= '0;
      end else begin
         if (stall)     stall_count      <= stall_count + OUT_W'(1);
         if (arith_hit) arith_count      <= arith_count + OUT_W'(1);
         if (mem_hit)   mem_access_count <= mem_access_count + OUT_W'(1);
      end
   end

`ifdef PMC_CPI_EN
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instr_cnt;
   logic [15:0]      cpi_next;
   logic [15:0]      cpi_q;

   // Both counters freeze together once cycle_cnt saturates so the ratio
   // stays meaningful instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else if (cycle_cnt != '1) begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (!stall) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

   pmc_q78_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .num (cycle_cnt),
      .den (instr_cnt),
      .q   (cpi_next)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpi_q <= '0;
      end else begin
         cpi_q <= cpi_next;
      end
   end

   assign cycles_per_instruction_q78 = OUT_W'(cpi_q);
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt                 = '0;
   assign cycles_per_instruction_q78 = '0;
`endif

endmodule

// File: tb/tb_pmc_unit.sv
module tb_pmc_unit;

   localparam int OUT_W = 256;
   localparam int CNT_W = 32;

   logic             clk;
   logic             reset;
   logic             memWrite_in;
   logic             memToReg_in;
   logic [2:0]       aluControl_in;
   logic [1:0]       stall_enable;
   logic [5:0]       opcode_in;
   logic [5:0]       funct_in;
   logic             jmp_in;
   logic [1:0]       branch_in;
   logic [OUT_W-1:0] stall_count;
   logic [OUT_W-1:0] cycles_per_instruction_q78;
   logic [OUT_W-1:0] arith_count;
   logic [OUT_W-1:0] mem_access_count;

   pmc_unit #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .memWrite_in                (memWrite_in),
      .memToReg_in                (memToReg_in),
      .aluControl_in              (aluControl_in),
      .stall_enable               (stall_enable),
      .opcode_in                  (opcode_in),
      .funct_in                   (funct_in),
      .jmp_in                     (jmp_in),
      .branch_in                  (branch_in),
      .stall_count                (stall_count),
      .cycles_per_instruction_q78 (cycles_per_instruction_q78),
      .arith_count                (arith_count),
      .mem_access_count           (mem_access_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One stimulus record: inputs plus the hand-derived increments it must cause.
   typedef struct {
      bit         rst_before;
      logic [1:0] se;
      logic       mw;
      logic       mr;
      logic       jmp;
      logic [1:0] br;
      logic [5:0] op;
      int         ds;
      int         da;
      int         dm;
      string      name;
   } vec_t;

   typedef struct {
      logic [OUT_W-1:0] st;
      logic [OUT_W-1:0] ar;
      logic [OUT_W-1:0] me;
      logic [OUT_W-1:0] cpi;
      string            name;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   int n_pass  = 0;
   int n_total = 0;

   // Reference totals and CPI state.
   logic [OUT_W-1:0] m_st, m_ar, m_me;
   longint           m_cyc, m_ins;

   function automatic vec_t mk(bit rb, logic [1:0] se, logic mw, logic mr, logic j,
                               logic [1:0] br, logic [5:0] op,
                               int ds, int da, int dm, string name);
      vec_t v;
      v.rst_before = rb; v.se = se; v.mw = mw; v.mr = mr; v.jmp = j;
      v.br = br; v.op = op; v.ds = ds; v.da = da; v.dm = dm; v.name = name;
      return v;
   endfunction

   task automatic chk(input string name, input logic [OUT_W-1:0] act,
                      input logic [OUT_W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".stall"}, stall_count, '0);
      chk({tag, ".arith"}, arith_count, '0);
      chk({tag, ".mem"},   mem_access_count, '0);
      chk({tag, ".cpi"},   cycles_per_instruction_q78, '0);
   endtask

   task automatic model_clear();
      m_st = '0; m_ar = '0; m_me = '0; m_cyc = 0; m_ins = 0;
   endtask

   // Starts and ends just after a falling edge. Asserts reset between edges and
   // checks the outputs clear before any rising edge occurs.
   task automatic do_reset(input string tag);
      #2 reset = 1'b0;
      #1 chk_zero({tag, ".async"});
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      #1;
   endtask

   // Drive one vector, push its expectation, compare after the rising edge.
   task automatic apply(input vec_t v);
      exp_t e;
      logic [15:0] cpi;
      longint q;
      stall_enable  = v.se;
      memWrite_in   = v.mw;
      memToReg_in   = v.mr;
      jmp_in        = v.jmp;
      branch_in     = v.br;
      opcode_in     = v.op;
      aluControl_in = 3'($urandom_range(0, 7));
      funct_in      = 6'($urandom_range(0, 63));
      cpi = 16'h0;
`ifdef PMC_CPI_EN
      if (m_ins != 0) begin
         q = (m_cyc * 256) / m_ins;
         cpi = (q > 64'hFFFF) ? 16'hFFFF : q[15:0];
      end
      m_cyc++;
      if (v.se == 2'b00) m_ins++;
`endif
      m_st = m_st + OUT_W'(v.ds);
      m_ar = m_ar + OUT_W'(v.da);
      m_me = m_me + OUT_W'(v.dm);
      e.st = m_st; e.ar = m_ar; e.me = m_me; e.cpi = OUT_W'(cpi); e.name = v.name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({v.name, ".scoreboard_empty"}, '1, '0);
      end else begin
         e = exp_q.pop_front();
         chk({e.name, ".stall"}, stall_count, e.st);
         chk({e.name, ".arith"}, arith_count, e.ar);
         chk({e.name, ".mem"},   mem_access_count, e.me);
         chk({e.name, ".cpi"},   cycles_per_instruction_q78, e.cpi);
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset held with random inputs: nothing may count.
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         stall_enable  = 2'($urandom_range(0, 3));
         memWrite_in   = 1'($urandom_range(0, 1));
         memToReg_in   = 1'($urandom_range(0, 1));
         jmp_in        = 1'($urandom_range(0, 1));
         branch_in     = 2'($urandom_range(0, 3));
         opcode_in     = 6'($urandom_range(0, 63));
         aluControl_in = 3'($urandom_range(0, 7));
         funct_in      = 6'($urandom_range(0, 63));
         @(posedge clk);
         #1 chk_zero("in_reset");
      end
      @(negedge clk);
      reset        = 1'b1;
      stall_enable = 2'b00; memWrite_in = 1'b0; memToReg_in = 1'b0;
      jmp_in = 1'b0; branch_in = 2'b00; opcode_in = 6'b000011;
      #1 chk_zero("released");

      // R-type run.
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b000000, 0, 1, 0, "rtype"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b010000, 0, 1, 0, "addi"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b000100, 0, 1, 0, "fp"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b001100, 0, 1, 0, "vfp"));
      // Memory accesses.
      tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 6'b010001, 0, 0, 1, "sw"));
      tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 6'b010010, 0, 0, 1, "lw"));
      tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 6'b010101, 0, 0, 1, "sw_fp"));
      tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 6'b010110, 0, 0, 1, "lw_fp"));
      tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 6'b011001, 0, 0, 1, "vst"));
      tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 6'b011010, 0, 0, 1, "vld"));
      // Control flow and non-arithmetic opcodes, some with an arithmetic opcode.
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b01, 6'b000000, 0, 0, 0, "beq"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b10, 6'b000000, 0, 0, 0, "blt"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 1, 2'b00, 6'b000000, 0, 0, 0, "jump"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b111111, 0, 0, 0, "vset"));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 2'b00, 6'b000011, 0, 0, 0, "op03"));
      // Fresh start: ADDs interleaved with data-hazard stalls, CPI -> 2.0.
      for (int i = 0; i < 4; i++) begin
         tbl.push_back(mk(i == 0, 2'b00, 0, 0, 0, 2'b00, 6'b000000, 0, 1, 0, "add_il"));
         tbl.push_back(mk(0, 2'b01, (i == 1), 0, 0, 2'b00, 6'b000000, 1, 0, 0, "stall_il"));
      end
      tbl.push_back(mk(0, 2'b10, 0, 1, 0, 2'b00, 6'b000000, 1, 0, 0, "ctl_stall_ld"));
      // Fresh start: stall-only cycles with both bits set.
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(i == 0, 2'b11, 0, 0, 0, 2'b00, 6'b000000, 1, 0, 0, "stall11"));

      foreach (tbl[i]) begin
         if (tbl[i].rst_before) do_reset(tbl[i].name);
         apply(tbl[i]);
      end

`ifdef PMC_CPI_EN
      // One more idle stall cycle to see the CPI register settle on 0 exactly.
      apply(mk(0, 2'b11, 0, 0, 0, 2'b00, 6'b000000, 1, 0, 0, "stall11_tail"));
`endif

      do_reset("final");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/pmc_unit.md
Name: pmc_unit

Overview:
Performance monitoring counter block for the pipelined CPU. It sits beside the execute stage and samples that stage's decoded control signals every clock. It counts stall cycles, arithmetic instructions and memory-access instructions. It also reports average cycles per instruction (CPI) as an unsigned Q7.8 value.

Parameters:
- OUT_W, 256, width of every output bus.
- CNT_W, 32, width of the internal cycle and instruction counters used for CPI.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- memWrite_in  in  1  store in execute stage
- memToReg_in  in  1  load in execute stage
- aluControl_in  in  3  ALU op code; informational only, not used for classification
- stall_enable  in  2  bit0 = data-hazard stall, bit1 = control-hazard stall
- opcode_in  in  6  execute-stage opcode
- funct_in  in  6  execute-stage funct; informational only
- jmp_in  in  1  jump
- branch_in  in  2  01 = BEQ, 10 = BLT, 00 = none
- stall_count  out  OUT_W  stall cycles counted
- cycles_per_instruction_q78  out  OUT_W  CPI in Q7.8, zero-extended (bits [15:0] used)
- arith_count  out  OUT_W  arithmetic instructions counted
- mem_access_count  out  OUT_W  memory-access instructions counted

Behaviour:
- Reset (reset=0, asynchronous): all counters, all outputs and the CPI register go to 0 immediately.
- All counting is sampled on the rising edge of clk while reset=1. Each counter output reflects its register directly, so a count shows one cycle after the event.
- stall = (stall_enable != 2'b00).
- stall_count: +1 per stall cycle. If both stall bits are set, it still adds only 1.
- Non-stall cycle: the sampled instruction is valid and is classified as below.
- Arithmetic instruction, all of the following true:
  - no stall;
  - memWrite_in=0, memToReg_in=0, jmp_in=0, branch_in=00;
  - opcode_in is one of 000000 (integer R-type), 010000 (ADDI), 000100 (scalar FP), 001100 (vector FP).
  - Every other opcode is not arithmetic; this includes 111111 VSET, 000011 and branch/jump opcodes.
- arith_count: +1 per arithmetic instruction.
- mem_access_count: +1 when there is no stall and (memWrite_in | memToReg_in).
- The three OUT_W-bit counters wrap modulo 2^OUT_W.
- Internal counters:
  - cycle_cnt: +1 every clock.
  - instr_cnt: +1 every non-stall cycle.
  - Both are CNT_W wide.
  - When cycle_cnt reaches all-ones, both stop changing until reset, keeping the ratio valid.
- CPI register, updated every clock from the current cycle_cnt and instr_cnt values (one-cycle latency, unsigned):
  - instr_cnt = 0: CPI = 0.
  - otherwise: CPI = floor(cycle_cnt * 256 / instr_cnt), saturated at 16'hFFFF.
  - Output is placed in bits [15:0]; upper bits are 0.
- aluControl_in and funct_in have no effect on any output.

Optional Feature:
- Macro PMC_CPI_EN.
- Defined: internal cycle/instruction counters and the divider are built, and CPI behaves as above.
- Undefined: none of that logic is built and cycles_per_instruction_q78 is constant 0. The other three counters are unaffected.

Decomposition:
- Shared package pmc_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_ADDI=010000, OP_FP=000100, OP_VFP=001100, OP_VSET=111111;
  - branch encodings BR_NONE=00, BR_EQ=01, BR_LT=10;
  - Q78_ONE=16'h0100.
- One sub-module, pmc_q78_div: combinational unsigned (CNT_W+8)/CNT_W divider with divide-by-zero → 0 and 16-bit saturation. Instantiated only under PMC_CPI_EN.

Test Plan:
1. Hold reset=0 with random inputs, then release → all outputs stay 0 until the first counted edge. Assert reset=0 mid-run → outputs clear without waiting for a clock.
2. 8 cycles of opcode 000000, stall_enable=00, all control 0 → arith_count=8, mem_access_count=0, stall_count=0. CPI=16'h0100 one cycle later.
3. 4 non-stall ADD cycles interleaved with 4 cycles at stall_enable=01 → stall_count=4, arith_count=4, CPI=16'h0200. A stall cycle with memWrite_in=1 does not increment mem_access_count.
4. SW (010001, memWrite=1), LW (010010, memToReg=1), SW.FP, LW.FP, VST, VLD, one cycle each → mem_access_count=6, arith_count unchanged.
5. BEQ (branch 01), BLT (branch 10), JUMP (jmp=1), VSET (111111), opcode 000011 → arith_count and mem_access_count unchanged; CPI stays 16'h0100.
6. Only stall cycles after reset (stall_enable=11 for 5 cycles) → stall_count=5 (one per cycle even with both bits set), CPI=0.
